// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
// Shared constants for the execute stage of the 32-bit ARM pipeline:
//   - ALU command encodings carried on exeCmd
//   - barrel-shifter type encodings carried in shOpr[6:5]
//   - bit positions of the {N,Z,C,V} status register
//   - a rotate-right helper used by the operand generator
// -----------------------------------------------------------------------------
package exe_pkg;

  localparam int unsigned DATA_W = 32;

  // ALU commands
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  // Shift types
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Status register bit indices
  localparam int unsigned SR_N = 3;
  localparam int unsigned SR_Z = 2;
  localparam int unsigned SR_C = 1;
  localparam int unsigned SR_V = 0;

  // Rotate right by 0..31. Doubling the word and shifting avoids a
  // shift-by-32 corner case when the amount is zero.
  function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] x,
                                              input logic [4:0]        n);
    logic [2*DATA_W-1:0] d;
    d = {x, x} >> n;
    return d[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/val2_gen.sv
// -----------------------------------------------------------------------------
// val2_gen
// Second-operand generator for the ALU (purely combinational).
//   rmVal     in  32  register operand Rm
//   shOpr     in  12  shifter operand field
//   imm       in   1  immediate operand form
//   memAccess in   1  load/store: use the raw 12-bit offset
//   val2      out 32  selected second operand
// Priority: memory offset, then rotated 8-bit immediate, then shifted Rm.
// -----------------------------------------------------------------------------
module val2_gen
  import exe_pkg::*;
(
  input  logic [DATA_W-1:0] rmVal,
  input  logic [11:0]       shOpr,
  input  logic              imm,
  input  logic              memAccess,
  output logic [DATA_W-1:0] val2
);

  logic [4:0] sh_amt;
  logic [1:0] sh_type;
  logic [4:0] rot_amt;

  assign sh_amt  = shOpr[11:7];
  assign sh_type = shOpr[6:5];
  // The 4-bit rotate field counts in steps of two bit positions.
  assign rot_amt = {shOpr[11:8], 1'b0};

  always_comb begin
    // NOTE: a default assignment at the top of every combinational block keeps
    // every path driving the output, so no latch can be inferred.
    val2 = rmVal;
    if (memAccess) begin
      val2 = {{(DATA_W-12){1'b0}}, shOpr};
    end else if (imm) begin
      val2 = ror32({{(DATA_W-8){1'b0}}, shOpr[7:0]}, rot_amt);
    end else begin
      // Every shift type reduces to rmVal when sh_amt is zero.
      unique case (sh_type)
        SH_LSL: val2 = rmVal << sh_amt;
        SH_LSR: val2 = rmVal >> sh_amt;
        SH_ASR: val2 = $unsigned($signed(rmVal) >>> sh_amt);
        SH_ROR: val2 = ror32(rmVal, sh_amt);
        default: val2 = rmVal;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage of the 32-bit ARM pipeline: Val2 generation, ALU, branch
// target adder, NZCV status register and the EX/MEM pipeline register.
//   clk, rst                        clock, synchronous active-high reset
//   wbEnIn/memrEnIn/memwEnIn        control bits from ID
//   sIn, bIn, exeCmdIn              flag update, branch, ALU command
//   pcIn, rnValIn, rmValIn          PC+4, Rn, Rm/store data
//   immIn, shOprIn, signedImm24In   operand form, shifter field, branch offset
//   destIn                          destination register
//   branchTaken, branchAddress      combinational branch outcome to fetch
//   srOut                           registered {N,Z,C,V} to decode
//   wbEnOut..destOut                registered EX/MEM bundle
// -----------------------------------------------------------------------------
module exe_stage
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH = 32  // only 32 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wbEnIn,
  input  logic             memrEnIn,
  input  logic             memwEnIn,
  input  logic             sIn,
  input  logic             bIn,
  input  logic [3:0]       exeCmdIn,
  input  logic [WIDTH-1:0] pcIn,
  input  logic [WIDTH-1:0] rnValIn,
  input  logic [WIDTH-1:0] rmValIn,
  input  logic             immIn,
  input  logic [11:0]      shOprIn,
  input  logic [23:0]      signedImm24In,
  input  logic [3:0]       destIn,
  output logic             branchTaken,
  output logic [WIDTH-1:0] branchAddress,
  output logic [3:0]       srOut,
  output logic             wbEnOut,
  output logic             memrEnOut,
  output logic             memwEnOut,
  output logic [WIDTH-1:0] aluResOut,
  output logic [WIDTH-1:0] storeValOut,
  output logic [3:0]       destOut
);

  logic [WIDTH-1:0] val2;
  logic [WIDTH:0]   sum;        // extra bit captures carry / no-borrow
  logic [WIDTH-1:0] alu_res_d;
  logic             c_d;
  logic             v_d;
  logic [3:0]       sr_d;

  logic [3:0]       sr_q;
  logic             wb_en_q;
  logic             memr_en_q;
  logic             memw_en_q;
  logic [WIDTH-1:0] alu_res_q;
  logic [WIDTH-1:0] store_val_q;
  logic [3:0]       dest_q;

  val2_gen u_val2_gen (
    .rmVal     (rmValIn),
    .shOpr     (shOprIn),
    .imm       (immIn),
    .memAccess (memrEnIn | memwEnIn),
    .val2      (val2)
  );

  // Branch target: word offset, sign-extended, wraps modulo 2^32.
  assign branchTaken   = bIn;
  assign branchAddress = pcIn + {{(WIDTH-26){signedImm24In[23]}}, signedImm24In, 2'b00};

  // ALU. Subtraction is rn + ~val2 + cin so that the carry out is directly
  // the ARM no-borrow flag; SBC supplies C as cin, giving rn - val2 - !C.
  always_comb begin
    alu_res_d = '0;
    sum       = '0;
    c_d       = sr_q[SR_C];
    v_d       = sr_q[SR_V];
    unique case (exeCmdIn)
      EXE_MOV: alu_res_d = val2;
      EXE_MVN: alu_res_d = ~val2;
      EXE_ADD, EXE_ADC: begin
        sum = {1'b0, rnValIn} + {1'b0, val2}
            + {{WIDTH{1'b0}}, (exeCmdIn == EXE_ADC) & sr_q[SR_C]};
        alu_res_d = sum[WIDTH-1:0];
        c_d       = sum[WIDTH];
        v_d       = (rnValIn[WIDTH-1] == val2[WIDTH-1]) &&
                    (alu_res_d[WIDTH-1] != rnValIn[WIDTH-1]);
      end
      EXE_SUB, EXE_SBC: begin
        sum = {1'b0, rnValIn} + {1'b0, ~val2}
            + {{WIDTH{1'b0}}, (exeCmdIn == EXE_SBC) ? sr_q[SR_C] : 1'b1};
        alu_res_d = sum[WIDTH-1:0];
        c_d       = sum[WIDTH];
        v_d       = (rnValIn[WIDTH-1] != val2[WIDTH-1]) &&
                    (alu_res_d[WIDTH-1] != rnValIn[WIDTH-1]);
      end
      EXE_AND: alu_res_d = rnValIn & val2;
      EXE_ORR: alu_res_d = rnValIn | val2;
      EXE_EOR: alu_res_d = rnValIn ^ val2;
      default: alu_res_d = '0;  // unknown command: zero result, C/V kept
    endcase
  end

  always_comb begin
    sr_d       = '0;
    sr_d[SR_N] = alu_res_d[WIDTH-1];
    sr_d[SR_Z] = (alu_res_d == '0);
    sr_d[SR_C] = c_d;
    sr_d[SR_V] = v_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sr_q        <= '0;
      wb_en_q     <= 1'b0;
      memr_en_q   <= 1'b0;
      memw_en_q   <= 1'b0;
      alu_res_q   <= '0;
      store_val_q <= '0;
      dest_q      <= '0;
    end else begin
      // Branches never touch the flags, even with sIn set.
      if (sIn && !bIn) begin
        sr_q <= sr_d;
      end
      wb_en_q     <= wbEnIn;
      memr_en_q   <= memrEnIn;
      memw_en_q   <= memwEnIn;
      alu_res_q   <= alu_res_d;
      store_val_q <= rmValIn;
      dest_q      <= destIn;
    end
  end

  assign srOut       = sr_q;
  assign wbEnOut     = wb_en_q;
  assign memrEnOut   = memr_en_q;
  assign memwEnOut   = memw_en_q;
  assign aluResOut   = alu_res_q;
  assign storeValOut = store_val_q;
  assign destOut     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
// Directed bench for exe_stage. Each step drives one ID/EX bundle on the
// falling edge, pushes the hand-derived EX/MEM expectation to a scoreboard,
// and pops/compares it one rising edge later. Branch outputs are compared
// combinationally in the drive cycle.
// -----------------------------------------------------------------------------
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbEnIn = 1'b0, memrEnIn = 1'b0, memwEnIn = 1'b0;
  logic        sIn = 1'b0, bIn = 1'b0, immIn = 1'b0;
  logic [3:0]  exeCmdIn = '0, destIn = '0;
  logic [31:0] pcIn = '0, rnValIn = '0, rmValIn = '0;
  logic [11:0] shOprIn = '0;
  logic [23:0] signedImm24In = '0;

  logic        branchTaken, wbEnOut, memrEnOut, memwEnOut;
  logic [31:0] branchAddress, aluResOut, storeValOut;
  logic [3:0]  srOut, destOut;

  exe_stage #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .wbEnIn        (wbEnIn),
    .memrEnIn      (memrEnIn),
    .memwEnIn      (memwEnIn),
    .sIn           (sIn),
    .bIn           (bIn),
    .exeCmdIn      (exeCmdIn),
    .pcIn          (pcIn),
    .rnValIn       (rnValIn),
    .rmValIn       (rmValIn),
    .immIn         (immIn),
    .shOprIn       (shOprIn),
    .signedImm24In (signedImm24In),
    .destIn        (destIn),
    .branchTaken   (branchTaken),
    .branchAddress (branchAddress),
    .srOut         (srOut),
    .wbEnOut       (wbEnOut),
    .memrEnOut     (memrEnOut),
    .memwEnOut     (memwEnOut),
    .aluResOut     (aluResOut),
    .storeValOut   (storeValOut),
    .destOut       (destOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  sr;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] store;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic s, input logic b,
                       input logic wb, input logic mr, input logic mw, input logic imm,
                       input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] sh,
                       input logic [3:0] dest, input logic [31:0] pc, input logic [23:0] off);
    @(negedge clk);
    exeCmdIn = cmd; sIn = s; bIn = b; wbEnIn = wb; memrEnIn = mr; memwEnIn = mw;
    immIn = imm; rnValIn = rn; rmValIn = rm; shOprIn = sh; destIn = dest;
    pcIn = pc; signedImm24In = off;
  endtask

  task automatic check_branch(input string tag, input logic taken, input logic [31:0] addr);
    #1;
    check({tag, ".taken"}, {31'b0, branchTaken}, {31'b0, taken});
    check({tag, ".addr"}, branchAddress, addr);
  endtask

  // Push the expectation for the bundle now on the inputs, then retire it
  // after the next rising edge.
  task automatic issue(input string tag, input logic [31:0] res, input logic [3:0] sr);
    exp_t e;
    e.tag = tag; e.res = res; e.sr = sr;
    if (rst) begin
      e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.store = '0; e.dest = '0;
    end else begin
      e.wb = wbEnIn; e.mr = memrEnIn; e.mw = memwEnIn; e.store = rmValIn; e.dest = destIn;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".res"},   aluResOut,            e.res);
    check({e.tag, ".sr"},    {28'b0, srOut},       {28'b0, e.sr});
    check({e.tag, ".wb"},    {31'b0, wbEnOut},     {31'b0, e.wb});
    check({e.tag, ".memr"},  {31'b0, memrEnOut},   {31'b0, e.mr});
    check({e.tag, ".memw"},  {31'b0, memwEnOut},   {31'b0, e.mw});
    check({e.tag, ".store"}, storeValOut,          e.store);
    check({e.tag, ".dest"},  {28'b0, destOut},     {28'b0, e.dest});
  endtask

  initial begin
    // Reset held two cycles with busy inputs.
    rst = 1'b1;
    drive(EXE_ADD, 1, 0, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 12'hABC, 4'hF, 32'h40, 24'h1);
    @(posedge clk);
    issue("reset", 32'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // ADD with signed overflow: 0x7FFFFFFF + 1.
    drive(EXE_ADD, 1, 0, 1, 0, 0, 1, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 12'h001, 4'h3, 32'h0, 24'h0);
    issue("add_ovf", 32'h8000_0000, 4'b1001);

    // Operand generator: rotated immediate and the four shift types.
    drive(EXE_MOV, 0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 12'h4FF, 4'h1, 32'h0, 24'h0);
    issue("mov_rot", 32'hFF00_0000, 4'b1001);
    drive(EXE_MOV, 0, 0, 1, 0, 0, 0, 32'h0, 32'h8000_0000, 12'h240, 4'h2, 32'h0, 24'h0);
    issue("mov_asr4", 32'hF800_0000, 4'b1001);
    drive(EXE_MOV, 0, 0, 1, 0, 0, 0, 32'h0, 32'h8000_0000, 12'h060, 4'h2, 32'h0, 24'h0);
    issue("mov_ror0", 32'h8000_0000, 4'b1001);
    drive(EXE_MOV, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0000_00F1, 12'h180, 4'h4, 32'h0, 24'h0);
    issue("mov_lsl3", 32'h0000_0788, 4'b1001);
    drive(EXE_MOV, 0, 0, 1, 0, 0, 0, 32'h0, 32'h8000_0010, 12'h220, 4'h5, 32'h0, 24'h0);
    issue("mov_lsr4", 32'h0800_0001, 4'b1001);
    drive(EXE_MOV, 0, 0, 1, 0, 0, 0, 32'h0, 32'h1234_5678, 12'h460, 4'h6, 32'h0, 24'h0);
    issue("mov_ror8", 32'h7812_3456, 4'b1001);

    // SUB then SBC back to back: SBC must see the fresh C=1.
    drive(EXE_SUB, 1, 0, 0, 0, 0, 1, 32'd5, 32'h0, 12'h005, 4'h0, 32'h0, 24'h0);
    issue("cmp_eq", 32'h0, 4'b0110);
    drive(EXE_SBC, 1, 0, 1, 0, 0, 1, 32'd5, 32'h0, 12'h003, 4'h7, 32'h0, 24'h0);
    issue("sbc_c1", 32'd2, 4'b0010);
    drive(EXE_ADC, 0, 0, 1, 0, 0, 1, 32'd1, 32'h0, 12'h001, 4'h7, 32'h0, 24'h0);
    issue("adc_c1", 32'd3, 4'b0010);

    // Borrow case clears C; the following SBC must subtract one more.
    drive(EXE_SUB, 1, 0, 1, 0, 0, 1, 32'd3, 32'h0, 12'h005, 4'h8, 32'h0, 24'h0);
    issue("sub_borrow", 32'hFFFF_FFFE, 4'b1000);
    drive(EXE_SBC, 1, 0, 1, 0, 0, 1, 32'd10, 32'h0, 12'h003, 4'h8, 32'h0, 24'h0);
    issue("sbc_c0", 32'd6, 4'b0010);

    // Signed overflow on subtract, carry out on add.
    drive(EXE_SUB, 1, 0, 1, 0, 0, 1, 32'h8000_0000, 32'h0, 12'h001, 4'h9, 32'h0, 24'h0);
    issue("sub_ovf", 32'h7FFF_FFFF, 4'b0011);
    drive(EXE_ADD, 1, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'h0, 12'h001, 4'h9, 32'h0, 24'h0);
    issue("add_carry", 32'h0, 4'b0110);

    // MVN and an undefined command keep C/V.
    drive(EXE_MVN, 1, 0, 1, 0, 0, 1, 32'h0, 32'h0, 12'h000, 4'hA, 32'h0, 24'h0);
    issue("mvn", 32'hFFFF_FFFF, 4'b1010);
    drive(4'b0000, 1, 0, 1, 0, 0, 1, 32'h1234, 32'h0, 12'h0FF, 4'hA, 32'h0, 24'h0);
    issue("undef_cmd", 32'h0, 4'b0110);

    // Logical ops on register operands (LSL #0).
    drive(EXE_AND, 0, 0, 1, 0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h000, 4'hB, 32'h0, 24'h0);
    issue("and", 32'hF000_F000, 4'b0110);
    drive(EXE_ORR, 0, 0, 1, 0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h000, 4'hB, 32'h0, 24'h0);
    issue("orr", 32'hFFF0_FFF0, 4'b0110);
    drive(EXE_EOR, 0, 0, 1, 0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h000, 4'hB, 32'h0, 24'h0);
    issue("eor", 32'h0FF0_0FF0, 4'b0110);

    // Load / store addresses: raw 12-bit offset, immIn ignored.
    drive(EXE_ADD, 0, 0, 1, 1, 0, 1, 32'h0000_0100, 32'h5555_AAAA, 12'hFFC, 4'hC, 32'h0, 24'h0);
    issue("ldr", 32'h0000_10FC, 4'b0110);
    drive(EXE_ADD, 0, 0, 0, 0, 1, 0, 32'h0000_0200, 32'hCAFE_F00D, 12'h010, 4'h0, 32'h0, 24'h0);
    issue("str", 32'h0000_0210, 4'b0110);

    // Branches: combinational target, flags untouched despite sIn=1.
    drive(EXE_SUB, 1, 1, 0, 0, 0, 1, 32'h0, 32'h0, 12'h001, 4'h0, 32'h20, 24'hFFFFFE);
    check_branch("b_back", 1'b1, 32'h18);
    issue("b_back", 32'hFFFF_FFFF, 4'b0110);
    drive(EXE_MOV, 0, 1, 0, 0, 0, 1, 32'h0, 32'h0, 12'h000, 4'h0, 32'h1000, 24'h000010);
    check_branch("b_fwd", 1'b1, 32'h1040);
    issue("b_fwd", 32'h0, 4'b0110);
    drive(EXE_MOV, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 12'h000, 4'h0, 32'hFFFF_FFF0, 24'h000008);
    check_branch("nb_wrap", 1'b0, 32'h10);
    issue("nb_wrap", 32'h0, 4'b0110);

    // Reset with an instruction in flight discards it and clears flags.
    drive(EXE_ADD, 1, 0, 1, 1, 0, 1, 32'h1, 32'h77, 12'h001, 4'hD, 32'h0, 24'h0);
    rst = 1'b1;
    issue("mid_reset", 32'h0, 4'b0000);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 32-bit ARM pipeline; consumes the ID/EX bundle produced by instruction decode.
- Contains the Val2 generator, the ALU, the branch-target adder and the NZCV status register.
- Registers the EX/MEM bundle for the memory stage.
- Returns branchTaken/branchAddress to fetch and the live status flags to decode.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wbEnIn  in  1  writeback enable from ID
- memrEnIn  in  1  load enable
- memwEnIn  in  1  store enable
- sIn  in  1  update flags
- bIn  in  1  branch
- exeCmdIn  in  4  ALU command
- pcIn  in  32  PC+4 of this instruction
- rnValIn  in  32  Rn operand
- rmValIn  in  32  Rm operand / store data
- immIn  in  1  immediate operand form
- shOprIn  in  12  shifter operand field
- signedImm24In  in  24  branch offset
- destIn  in  4  destination register
- branchTaken  out  1  combinational, equals bIn
- branchAddress  out  32  combinational branch target
- srOut  out  4  status register {N,Z,C,V}, registered
- wbEnOut  out  1  registered
- memrEnOut  out  1  registered
- memwEnOut  out  1  registered
- aluResOut  out  32  registered ALU result / memory address
- storeValOut  out  32  registered rmValIn
- destOut  out  4  registered

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset: on the clk edge with rst=1, all registered outputs and srOut become 0. rst has priority over every other event. An instruction in flight during reset is discarded.
- Latency: 1 cycle from the ID inputs to the EX/MEM outputs. branchTaken and branchAddress are combinational in the same cycle.
- Val2 selection, in priority order:
  - memrEnIn|memwEnIn: zero-extended shOprIn[11:0].
  - immIn=1: {24'b0,shOprIn[7:0]} rotated right by 2*shOprIn[11:8].
  - Otherwise rmValIn shifted by shOprIn[11:7] (0..31). Shift type shOprIn[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes rmValIn unchanged for all four types.
- ALU commands (C = srOut[1]):
  - 0001 MOV: val2
  - 1001 MVN: ~val2
  - 0010 ADD: rn+val2
  - 0011 ADC: rn+val2+C
  - 0100 SUB: rn-val2
  - 0101 SBC: rn-val2-!C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags N/Z from the result, C and V unchanged.
  - CMP and TST arrive as SUB and AND with wbEnIn=0. LDR and STR arrive as ADD.
- Flag computation:
  - N = res[31]; Z = (res==0).
  - ADD/ADC: C = carry out; V = (rn[31]==val2[31]) && (res[31]!=rn[31]).
  - SUB/SBC: C = no-borrow (1 when no borrow occurs); V = (rn[31]!=val2[31]) && (res[31]!=rn[31]).
  - Logical ops and MOV/MVN: C and V are preserved.
  - All arithmetic is modulo 2^32.
- Status register:
  - Loads the computed flags at the clk edge when sIn=1 and bIn=0; otherwise it holds.
  - An ADC/SBC issued right after a flag-setting instruction reads the already-updated srOut. The edge update makes this hold.
- branchAddress = pcIn + sign-extended {signedImm24In,2'b00}, in 32-bit wraparound arithmetic.
- EX/MEM registers:
  - Load every cycle with no stall.
  - When bIn=1 the stage still registers the bundle. ID delivers wbEn/mem enables of 0 for branches.

Decomposition:
- Shared package exe_pkg:
  - exeCmd localparams (EXE_MOV … EXE_EOR).
  - Shift-type constants (SH_LSL, SH_LSR, SH_ASR, SH_ROR).
  - Status flag bit indices (SR_N=3, SR_Z=2, SR_C=1, SR_V=0).
- One combinational sub-module, val2_gen: inputs rmVal, shOpr, imm, memAccess; output val2.
- The ALU and status register stay in exe_stage.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with arbitrary inputs -> all outputs 0, srOut=0000. Release rst -> the first instruction appears one cycle later.
2. ADD with flags: rn=0x7FFFFFFF, immIn=1, shOpr=0x001, exeCmd=0010, sIn=1 -> aluResOut=0x80000000, srOut=1001 (N,V) next cycle.
3. Immediate rotate and register shift:
   - shOpr=0x4FF, imm=1, MOV -> aluResOut=0xFF000000.
   - rm=0x80000000, shOpr={5'd4,2'b10,5'b0}, MOV -> 0xF8000000.
   - Same with ROR amount 0 -> 0x80000000.
4. SUB/SBC chain:
   - SUB rn=5, val2=5, sIn=1 -> res 0, srOut=0110 (Z,C).
   - Next cycle SBC rn=5, val2=3 -> res 2; C=1 is used, so no extra decrement.
5. Load address: memrEnIn=1, rn=0x100, shOpr=0xFFC (imm ignored) -> aluResOut=0x10FC, memrEnOut=1, storeValOut=rmValIn.
6. Branch: bIn=1, pcIn=0x20, imm24=0xFFFFFE -> branchTaken=1 and branchAddress=0x18 in the same cycle; srOut unchanged even with sIn=1.
